// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, signed/unsigned,
// constant latency of WIDTH+2 edges from acceptance to the DONE cycle.
module seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div0
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t             r_state;
   logic               r_sign;
   logic [WIDTH-1:0]   r_dvd_in;
   logic [WIDTH-1:0]   r_dvs;
   logic [WIDTH-1:0]   r_dvd_sr;
   logic [WIDTH:0]     r_rem;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_zero;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_quot;
   logic [WIDTH-1:0]   r_remd;
   logic               r_div0;

   logic [WIDTH-1:0]   w_dvd_abs;
   logic [WIDTH-1:0]   w_dvs_abs;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic               w_cout;
   logic               w_nb;
   logic [WIDTH-1:0]   w_q_fix;
   logic [WIDTH-1:0]   w_r_fix;

   assign w_dvd_abs = (r_sign && r_dvd_in[WIDTH-1]) ? (~r_dvd_in + WIDTH'(1)) : r_dvd_in;
   assign w_dvs_abs = (r_sign && r_dvs[WIDTH-1])    ? (~r_dvs + WIDTH'(1))    : r_dvs;

   // Trial subtract as add of inverted divisor with carry-in 1; carry-out 1 = no borrow
   assign w_shift = {r_rem[WIDTH-1:0], r_dvd_sr[WIDTH-1]};
   assign {w_cout, w_diff} = {1'b0, w_shift} + {1'b0, ~{1'b0, r_dvs}} + (WIDTH+2)'(1);
   // Partial remainder stays below the divisor, so its top bit only ever adds safety here
   assign w_nb = w_cout | r_rem[WIDTH];

   assign w_q_fix = r_neg_q ? (~r_dvd_sr + WIDTH'(1)) : r_dvd_sr;
   assign w_r_fix = r_neg_r ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_sign   <= 1'b0;
         r_dvd_in <= '0;
         r_dvs    <= '0;
         r_dvd_sr <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_zero   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_quot   <= '0;
         r_remd   <= '0;
         r_div0   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sign   <= sign;
                  r_dvd_in <= dividend;
                  r_dvs    <= divisor;
                  r_busy   <= 1'b1;
                  r_state  <= S_PREP;
               end
            end
            S_PREP: begin
               r_dvs    <= w_dvs_abs;
               r_dvd_sr <= w_dvd_abs;
               r_neg_q  <= r_sign & (r_dvd_in[WIDTH-1] ^ r_dvs[WIDTH-1]);
               r_neg_r  <= r_sign & r_dvd_in[WIDTH-1];
               r_zero   <= (r_dvs == '0);
               r_rem    <= '0;
               r_cnt    <= '0;
               r_state  <= S_RUN;
            end
            S_RUN: begin
               r_rem    <= w_nb ? w_diff : w_shift;
               r_dvd_sr <= {r_dvd_sr[WIDTH-2:0], w_nb};
               if (r_cnt == CNT_W'(WIDTH-1)) begin
                  r_state <= S_FIX;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_FIX: begin
               r_quot  <= r_zero ? '1 : w_q_fix;
               r_remd  <= r_zero ? r_dvd_in : w_r_fix;
               r_div0  <= r_zero;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign quotient  = r_quot;
   assign remainder = r_remd;
   assign div0      = r_div0;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH = 8 (latency 10 edges).
module tb_seq_divider;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned LAT   = WIDTH + 2;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic             sign;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div0;

   int n_tests = 0;
   int n_fail  = 0;

   seq_divider #(.WIDTH(WIDTH)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .sign      (sign),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div0      (div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one operation; optionally pulse start with other operands 4 cycles in.
   task automatic run_div(input string tag, input logic s, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_q,
                          input logic [WIDTH-1:0] exp_r, input logic exp_d0,
                          input logic glitch);
      int n;
      int busy_low;
      int extra_done;
      @(negedge clk);
      start = 1'b1; sign = s; dividend = a; divisor = b;
      @(posedge clk); #1;
      start = 1'b0; dividend = 8'hA5; divisor = 8'h3C;
      n = 0; busy_low = 0;
      while (n < 40) begin
         if (glitch && n == 4) begin
            start = 1'b1; sign = 1'b0; dividend = 8'd7; divisor = 8'd2;
         end
         @(posedge clk); #1;
         start = 1'b0;
         n++;
         if (!busy) busy_low++;
         if (done) break;
      end
      check({tag, " latency"}, 32'(n), 32'(LAT));
      check({tag, " busy_gaps"}, 32'(busy_low), 32'd0);
      check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
      check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
      check({tag, " div0"}, 32'(div0), 32'(exp_d0));
      @(posedge clk); #1;
      check({tag, " done_pulse"}, 32'(done), 32'd0);
      check({tag, " busy_end"}, 32'(busy), 32'd0);
      if (glitch) begin
         extra_done = 0;
         for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
         end
         check({tag, " single_done"}, 32'(extra_done), 32'd0);
         check({tag, " held_q"}, 32'(quotient), 32'(exp_q));
      end
   endtask

   initial begin
      int dones;
      reset_n = 1'b0; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
      #12;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset q", 32'(quotient), 32'd0);
      check("reset r", 32'(remainder), 32'd0);
      check("reset div0", 32'(div0), 32'd0);
      @(negedge clk); reset_n = 1'b1;

      run_div("u100/7",   1'b0, 8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 1'b0);
      run_div("s-100/7",  1'b1, 8'h9C,  8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0);
      run_div("s100/-7",  1'b1, 8'h64,  8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);
      run_div("s-100/-7", 1'b1, 8'h9C,  8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0);
      run_div("s_ovf",    1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b0);
      run_div("uFF/1",    1'b0, 8'hFF,  8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
      run_div("u5/9",     1'b0, 8'd5,   8'd9,  8'h00, 8'h05, 1'b0, 1'b0);
      run_div("u_div0",   1'b0, 8'h5A,  8'h00, 8'hFF, 8'h5A, 1'b1, 1'b0);
      run_div("s_div0",   1'b1, 8'h5A,  8'h00, 8'hFF, 8'h5A, 1'b1, 1'b0);
      run_div("u9/3",     1'b0, 8'd9,   8'd3,  8'h03, 8'h00, 1'b0, 1'b0);
      run_div("glitch",   1'b0, 8'd50,  8'd5,  8'h0A, 8'h00, 1'b0, 1'b1);
      run_div("u13/4",    1'b0, 8'd13,  8'd4,  8'h03, 8'h01, 1'b0, 1'b0);

      // Abort mid-RUN with an asynchronous reset
      @(negedge clk);
      start = 1'b1; sign = 1'b0; dividend = 8'd99; divisor = 8'd4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("abort q", 32'(quotient), 32'd0);
      check("abort r", 32'(remainder), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         if (done || busy) dones++;
      end
      check("abort no_done", 32'(dones), 32'd0);
      run_div("u20/6", 1'b0, 8'd20, 8'd6, 8'h03, 8'h02, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
